round_sequencer: RTL and testbench
==================================

# round_sequencer

Round controller for the Lab 4 pattern game. It strobes the `next_state` pattern generator once per round and appends each new 6-bit pattern to an internal sequence buffer. It then plays the whole sequence back on the display, paced by a slow tick, and checks the player's switch entries against it. It sits between the pattern generator, the switch/button inputs (debounced upstream) and the display driver.

## Interface
- `MAX_LEN`, 8: maximum sequence length (rounds to win); 1..15.
- `SHOW_TICKS`, 4: `tick_in` pulses each symbol is displayed.
- `GAP_TICKS`, 1: `tick_in` pulses of blank display between symbols.

Ports:
- `clk_in`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick_in`  in  1  one-cycle time-base pulse, slow relative to `clk_in`.
- `start`  in  1  one-cycle pulse that begins a new game.
- `gen_state`  in  6  current output of the pattern generator.
- `gen_play`  out  1  one-cycle strobe to the generator's `play` input.
- `guess`  in  6  player switch value.
- `submit`  in  1  one-cycle pulse that commits `guess`.
- `show_value`  out  6  symbol to display; 0 when `show_valid`=0.
- `show_valid`  out  1  display enable.
- `awaiting_input`  out  1  high in INPUT.
- `level`  out  4  number of stored symbols (0..MAX_LEN).
- `win`  out  1  high in WIN.
- `lose`  out  1  high in LOSE.

## Operation
- Storage: `buf[0..MAX_LEN-1]` holds 6-bit symbols. `len` is a 4-bit count and drives `level`. `idx` is a 4-bit index. `tcnt` counts ticks.
- States and transitions:
  - IDLE: wait for `start`. On `start`, clear `len` and go to GEN.
  - GEN: `gen_play`=1 for exactly this cycle. Next state is CAPTURE.
  - CAPTURE: `buf[len]` <= `gen_state` and `len` <= `len`+1. Clear `idx` and `tcnt`, then go to SHOW.
  - SHOW: `show_valid`=1 and `show_value`=`buf[idx]`. Each sampled `tick_in` increments `tcnt`. On the SHOW_TICKS-th tick, clear `tcnt` and go to GAP.
  - GAP: `show_valid`=0. On the GAP_TICKS-th tick, clear `tcnt`.
    - If `idx`=`len`-1, clear `idx` and go to INPUT.
    - Otherwise increment `idx` and go to SHOW.
  - INPUT: `awaiting_input`=1. On `submit`, compare `guess` with `buf[idx]`.
    - Mismatch: go to LOSE.
    - Match with `idx`<`len`-1: increment `idx`.
    - Match with `idx`=`len`-1: go to WIN if `len`=MAX_LEN, otherwise go to GEN.
  - WIN, LOSE: hold `level` and raise `win` or `lose`. On `start`, clear `len` and go to GEN.
- Ignored inputs:
  - `start` is ignored in GEN, CAPTURE, SHOW, GAP and INPUT.
  - `submit` is ignored outside INPUT.
  - `tick_in` is ignored outside SHOW and GAP.
- Comparison is a full 6-bit equality; there is no partial credit.
- `len` never exceeds MAX_LEN, and the buffer is never written past index MAX_LEN-1.

## Timing
- Reset (`rst_n`=0 at a rising edge), from any state including mid-SHOW or mid-INPUT:
  - Next state is IDLE.
  - `len`, `idx` and `tcnt` are cleared to 0.
  - All outputs are 0, including `show_value`.
  - Buffer contents are don't-care.
- `start` to `gen_play`: `gen_play` is high in the cycle after `start` is sampled.
- Capture timing:
  - The generator loads its output register on the edge that samples `gen_play`=1, so its new value appears in the cycle after GEN.
  - CAPTURE latches `gen_state` at the end of that cycle, i.e. at the second edge after GEN.
  - SHOW begins two cycles after GEN.
- Tick counting:
  - A `tick_in` coinciding with the state-entry edge is not counted; counting starts in the first cycle spent in the state.
  - SHOW therefore lasts exactly SHOW_TICKS tick pulses, and GAP exactly GAP_TICKS tick pulses.
- Submit: a `submit` sampled in INPUT is evaluated in that cycle, and the resulting state takes effect on the next edge. Back-to-back `submit` pulses in consecutive cycles are each evaluated.
- Game end: `win` and `lose` assert one cycle after the deciding `submit`.
- Outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst_n`=0 for 2 cycles in the middle of SHOW. Required: IDLE, `level`=0 and all outputs 0 on the next edge. A `submit` in IDLE has no effect.
- First round: model the generator returning 0x2A after a strobe, then pulse `start`. Required:
  - `gen_play` high for exactly 1 cycle.
  - `level`=1.
  - `show_value`=0x2A with `show_valid`=1 for exactly 4 ticks, then 1 blank tick.
  - `awaiting_input`=1 after the blank tick.
- Progression: generator sequence 0x2A, 0x11, 0x3F with correct guesses each round. Required:
  - `level` steps 1→2→3.
  - Each playback shows the full stored prefix, in order.
- Loss: at level 2, submit 0x2A and then 0x10 (expected 0x11). Required:
  - `lose`=1 and `level` stays at 2.
  - `start` then restarts the game with `level`=1 and a new `gen_play`.
- Win: with MAX_LEN=8, enter all 8 rounds correctly. Required: `win`=1 with `level`=8 after the 8th correct submit, and no 9th `gen_play`.
- Ignored events: pulse `submit` and `start` during SHOW, and `tick_in` on the same cycle as entering SHOW. Required:
  - No state change.
  - The SHOW duration is still exactly 4 counted ticks.

Source files
------------

// File: rtl/round_sequencer.sv
// round_sequencer: round controller for the pattern memory game.
// Each round it strobes the pattern generator once, appends the new 6-bit symbol to a
// sequence buffer, plays the whole sequence back on the display (paced by tick_in), then
// checks the player's guesses against it in order.
//
// Ports:
//   clk_in          system clock, rising edge
//   rst_n           synchronous active-low reset
//   tick_in         one-cycle slow time-base pulse (display pacing)
//   start           one-cycle pulse, begins a new game from IDLE/WIN/LOSE
//   gen_state[5:0]  current pattern generator output
//   gen_play        one-cycle strobe to the generator
//   guess[5:0]      player switch value
//   submit          one-cycle pulse committing guess
//   show_value[5:0] displayed symbol (0 when show_valid=0)
//   show_valid      display enable
//   awaiting_input  high while waiting for the player's guesses
//   level[3:0]      number of stored symbols
//   win, lose       game result flags
module round_sequencer #(
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned SHOW_TICKS = 4,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start,
  input  logic [5:0] gen_state,
  output logic       gen_play,
  input  logic [5:0] guess,
  input  logic       submit,
  output logic [5:0] show_value,
  output logic       show_valid,
  output logic       awaiting_input,
  output logic [3:0] level,
  output logic       win,
  output logic       lose
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StGen     = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StShow    = 3'd3;
  localparam logic [2:0] StGap     = 3'd4;
  localparam logic [2:0] StInput   = 3'd5;
  localparam logic [2:0] StWin     = 3'd6;
  localparam logic [2:0] StLose    = 3'd7;

  localparam logic [3:0] MaxLen   = 4'(MAX_LEN);
  localparam logic [7:0] ShowLast = 8'(SHOW_TICKS - 1);
  localparam logic [7:0] GapLast  = 8'(GAP_TICKS - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] len_q, len_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       cap_en;
  logic [3:0] last_idx;
  logic [5:0] cur_sym;
  logic [5:0] seq_buf [MAX_LEN];

  assign last_idx = len_q - 4'd1;

  // Mux by explicit compare so the 4-bit index never addresses past MAX_LEN-1.
  always_comb begin
    cur_sym = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (idx_q == 4'(i)) cur_sym = seq_buf[i];
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    cap_en  = 1'b0;
    case (state_q)
      StIdle, StWin, StLose: begin
        if (start) begin
          len_d   = '0;
          state_d = StGen;
        end
      end
      StGen: state_d = StCapture;
      StCapture: begin
        // The win check keeps len <= MAX_LEN; the guard makes that structural.
        if (len_q < MaxLen) begin
          cap_en = 1'b1;
          len_d  = len_q + 4'd1;
        end
        idx_d   = '0;
        tcnt_d  = '0;
        state_d = StShow;
      end
      StShow: begin
        if (tick_in) begin
          if (tcnt_q == ShowLast) begin
            tcnt_d  = '0;
            state_d = StGap;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      StGap: begin
        if (tick_in) begin
          if (tcnt_q == GapLast) begin
            tcnt_d = '0;
            if (idx_q == last_idx) begin
              idx_d   = '0;
              state_d = StInput;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = StShow;
            end
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      StInput: begin
        if (submit) begin
          if (guess != cur_sym) begin
            state_d = StLose;
          end else if (idx_q != last_idx) begin
            idx_d = idx_q + 4'd1;
          end else if (len_q == MaxLen) begin
            state_d = StWin;
          end else begin
            state_d = StGen;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk_in) begin
    if (cap_en) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        if (len_q == 4'(i)) seq_buf[i] <= gen_state;
      end
    end
  end

  assign gen_play       = (state_q == StGen);
  assign show_valid     = (state_q == StShow);
  assign show_value     = show_valid ? cur_sym : 6'h00;
  assign awaiting_input = (state_q == StInput);
  assign level          = len_q;
  assign win            = (state_q == StWin);
  assign lose           = (state_q == StLose);

endmodule

// File: tb/tb_round_sequencer.sv
`timescale 1ns/1ps
module tb_round_sequencer;
  localparam int MAXL   = 8;
  localparam int SHOWT  = 4;
  localparam int GAPT   = 1;
  localparam int PERIOD = SHOWT + GAPT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [5:0] gen_state = 6'h00;
  logic [5:0] guess = 6'h00;
  logic       gen_play, show_valid, awaiting_input, win, lose;
  logic [5:0] show_value;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;
  int gp_count = 0;

  round_sequencer #(.MAX_LEN(MAXL), .SHOW_TICKS(SHOWT), .GAP_TICKS(GAPT)) dut (
    .clk_in(clk), .rst_n(rst_n), .tick_in(tick_in), .start(start),
    .gen_state(gen_state), .gen_play(gen_play), .guess(guess), .submit(submit),
    .show_value(show_value), .show_valid(show_valid), .awaiting_input(awaiting_input),
    .level(level), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // Pattern generator stand-in: output register loads on the edge that samples gen_play.
  logic [5:0] gen_list [32];
  int g_idx = 0;
  always @(posedge clk) begin
    if (gen_play === 1'b1) begin
      gen_state <= gen_list[g_idx];
      g_idx <= g_idx + 1;
    end
  end

  always @(negedge clk) if (gen_play === 1'b1) gp_count++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game phases, symbol queue, and playback as elapsed tick count.
  typedef enum int {PIdle, PGen, PCap, PPlay, PInput, PWin, PLose} phase_t;
  phase_t     m_phase = PIdle;
  logic [5:0] m_seq[$];
  int         m_p = 0;
  int         m_pos = 0;
  int         m_gen = 0;
  bit         mv = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = PIdle;
      m_seq.delete();
      m_p = 0;
      m_pos = 0;
      mv = 1'b1;
    end else begin
      case (m_phase)
        PIdle, PWin, PLose: if (start) begin m_seq.delete(); m_phase = PGen; end
        PGen: m_phase = PCap;
        PCap: begin
          if (m_seq.size() < MAXL) m_seq.push_back(gen_list[m_gen]);
          m_gen++;
          m_p = 0;
          m_phase = PPlay;
        end
        PPlay: if (tick_in) begin
          m_p++;
          if (m_p == m_seq.size() * PERIOD) begin m_phase = PInput; m_pos = 0; end
        end
        PInput: if (submit) begin
          if (guess != m_seq[m_pos]) m_phase = PLose;
          else if (m_pos < m_seq.size() - 1) m_pos++;
          else if (m_seq.size() == MAXL) m_phase = PWin;
          else m_phase = PGen;
        end
        default: m_phase = PIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    logic       exp_sv;
    logic [5:0] exp_val;
    if (mv) begin
      exp_sv  = (m_phase == PPlay) && ((m_p % PERIOD) < SHOWT);
      exp_val = exp_sv ? m_seq[m_p / PERIOD] : 6'h00;
      check("cyc_gen_play", 8'(gen_play), 8'(m_phase == PGen));
      check("cyc_show_valid", 8'(show_valid), 8'(exp_sv));
      check("cyc_show_value", 8'(show_value), 8'(exp_val));
      check("cyc_awaiting", 8'(awaiting_input), 8'(m_phase == PInput));
      check("cyc_level", 8'(level), 8'(m_seq.size()));
      check("cyc_win", 8'(win), 8'(m_phase == PWin));
      check("cyc_lose", 8'(lose), 8'(m_phase == PLose));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick1();
    tick_in = 1'b1; step(); tick_in = 1'b0; step();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick1();
  endtask

  task automatic enter(input logic [5:0] g);
    guess = g; submit = 1'b1; step(); submit = 1'b0; step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 8'(level), 8'h00);
    check({tag, "_show_valid"}, 8'(show_valid), 8'h00);
    check({tag, "_show_value"}, 8'(show_value), 8'h00);
    check({tag, "_gen_play"}, 8'(gen_play), 8'h00);
    check({tag, "_awaiting"}, 8'(awaiting_input), 8'h00);
    check({tag, "_win"}, 8'(win), 8'h00);
    check({tag, "_lose"}, 8'(lose), 8'h00);
  endtask

  initial begin
    gen_list[0] = 6'h2A; gen_list[1] = 6'h11;
    gen_list[2] = 6'h2A; gen_list[3] = 6'h11; gen_list[4] = 6'h3F; gen_list[5] = 6'h05;
    gen_list[6] = 6'h30; gen_list[7] = 6'h0C; gen_list[8] = 6'h21; gen_list[9] = 6'h1E;
    for (int i = 10; i < 32; i++) gen_list[i] = 6'(i * 7 + 3);

    // Power-on reset, then a submit in IDLE must do nothing.
    step(); step();
    check_all_zero("por");
    rst_n = 1'b1; step();
    enter(6'h2A);
    check_all_zero("idle_submit");

    // First round with ignored events around SHOW.
    start = 1'b1; step(); start = 1'b0;
    check("r1_gen_play_hi", 8'(gen_play), 8'h01);
    step();
    check("r1_gen_play_lo", 8'(gen_play), 8'h00);
    tick_in = 1'b1; step(); tick_in = 1'b0;  // tick on the SHOW-entry edge
    check("r1_show_valid", 8'(show_valid), 8'h01);
    check("r1_show_value", 8'(show_value), 8'h2A);
    check("r1_level", 8'(level), 8'h01);
    guess = 6'h2A; submit = 1'b1; step(); submit = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check("r1_ignored_still_show", 8'(show_valid), 8'h01);
    ticks(3);
    check("r1_after3_show", 8'(show_valid), 8'h01);
    tick1();
    check("r1_after4_blank", 8'(show_valid), 8'h00);
    check("r1_after4_not_input", 8'(awaiting_input), 8'h00);
    tick1();
    check("r1_after5_input", 8'(awaiting_input), 8'h01);
    check("r1_gp_count", 8'(gp_count), 8'h01);

    // Round 2, then lose with 0x10 in place of 0x11.
    enter(6'h2A); step();
    check("r2_level", 8'(level), 8'h02);
    check("r2_first_sym", 8'(show_value), 8'h2A);
    ticks(2 * PERIOD);
    check("r2_input", 8'(awaiting_input), 8'h01);
    enter(6'h2A);
    check("loss_mid_input", 8'(awaiting_input), 8'h01);
    enter(6'h10);
    check("loss_lose", 8'(lose), 8'h01);
    check("loss_level", 8'(level), 8'h02);
    step();
    check("loss_hold", 8'(lose), 8'h01);

    // Restart and play a full game to WIN.
    start = 1'b1; step(); start = 1'b0;
    check("restart_gen_play", 8'(gen_play), 8'h01);
    step(); step();
    check("restart_level", 8'(level), 8'h01);
    check("restart_gp_count", 8'(gp_count), 8'h03);
    for (int r = 1; r <= MAXL; r++) begin
      check("game_level", 8'(level), 8'(r));
      check("game_first_sym", 8'(show_value), 8'(gen_list[2]));
      ticks(r * PERIOD);
      check("game_input", 8'(awaiting_input), 8'h01);
      for (int k = 0; k < r; k++) enter(gen_list[2 + k]);
      if (r < MAXL) step();
    end
    check("win_flag", 8'(win), 8'h01);
    check("win_level", 8'(level), 8'h08);
    repeat (4) step();
    check("win_no_9th_gen", 8'(gp_count), 8'd10);
    check("win_hold", 8'(win), 8'h01);

    // Reset in the middle of SHOW.
    start = 1'b1; step(); start = 1'b0; step(); step();
    check("rst_pre_show", 8'(show_valid), 8'h01);
    tick1();
    rst_n = 1'b0; step();
    check_all_zero("rst_edge1");
    step();
    check_all_zero("rst_edge2");
    rst_n = 1'b1; step();
    enter(gen_list[10]);
    check_all_zero("rst_idle_submit");
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
